// File: rtl/mips_data_mem_if.sv
// Request/response bundle between a load/store unit and mips_data_mem.
// master drives requests and store data; slave returns load data and status.
interface mips_data_mem_if;
  logic        signal_mem_read;
  logic        signal_mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [1:0]  access_size;
  logic        signal_unsigned;
  logic [31:0] read_data;
  logic        mem_ready;
  logic        mem_error;
  logic        mem_busy;

  modport master (
    output signal_mem_read,
    output signal_mem_write,
    output address,
    output write_data,
    output access_size,
    output signal_unsigned,
    input  read_data,
    input  mem_ready,
    input  mem_error,
    input  mem_busy
  );

  modport slave (
    input  signal_mem_read,
    input  signal_mem_write,
    input  address,
    input  write_data,
    input  access_size,
    input  signal_unsigned,
    output read_data,
    output mem_ready,
    output mem_error,
    output mem_busy
  );
endinterface

// File: rtl/mips_data_mem.sv
// Big-endian MIPS data memory, byte/half/word access, fixed wait states.
// Ports: clk, rst_n (async, active-low), bus (mips_data_mem_if.slave).
// MIPS_DATA_MEM_ALIGN_CHECK_EN: flag misaligned half/word as errors.
module mips_data_mem #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mips_data_mem_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          wr_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic [31:0]   data_memory [0:DEPTH-1];

  logic          accept;
  logic          finish;
  logic          bad_align;
  logic          bad;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [4:0]    bsh;
  logic [4:0]    hsh;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   rext;
  logic [31:0]   wmask;
  logic [31:0]   wshift;
  logic [31:0]   wnew;

  assign accept = (state_q == IDLE) &&
                  (bus.signal_mem_read || bus.signal_mem_write);
  assign finish = (state_q == BUSY) && (cnt_q == 4'd0);

`ifdef MIPS_DATA_MEM_ALIGN_CHECK_EN
  assign bad_align =
    ((bus.access_size == 2'b01) && bus.address[0]) ||
    ((bus.access_size == 2'b10) && (bus.address[1:0] != 2'b00));
`else
  assign bad_align = 1'b0;
`endif

  assign bad = (bus.signal_mem_read && bus.signal_mem_write) ||
               (bus.access_size == 2'b11) ||
               (|bus.address[31:AW+2]) ||
               bad_align;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = LAT;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else cnt_d = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.address[AW+1:0];
        wdata_q <= bus.write_data;
        size_q  <= bus.access_size;
        uns_q   <= bus.signal_unsigned;
        wr_q    <= bus.signal_mem_write;
        err_q   <= bad;
      end
      if (finish && !wr_q && !err_q) rdata_q <= rext;
    end
  end

  // Byte lane 0 sits in bits [31:24], so the shift is (3-lane)*8.
  assign idx   = addr_q[AW+1:2];
  assign word  = data_memory[idx];
  assign bsh   = {~addr_q[1:0], 3'b000};
  assign hsh   = {~addr_q[1], 4'b0000};
  assign rbyte = 8'(word >> bsh);
  assign rhalf = 16'(word >> hsh);

  always_comb begin
    rext   = word;
    wmask  = '1;
    wshift = wdata_q;
    unique case (1'b1)
      (size_q == 2'b00): begin
        rext   = uns_q ? {24'b0, rbyte}
                       : {{24{rbyte[7]}}, rbyte};
        wmask  = 32'h0000_00ff << bsh;
        wshift = {24'b0, wdata_q[7:0]} << bsh;
      end
      (size_q == 2'b01): begin
        rext   = uns_q ? {16'b0, rhalf}
                       : {{16{rhalf[15]}}, rhalf};
        wmask  = 32'h0000_ffff << hsh;
        wshift = {16'b0, wdata_q[15:0]} << hsh;
      end
      default: begin
        rext   = word;
        wmask  = '1;
        wshift = wdata_q;
      end
    endcase
  end

  assign wnew = (word & ~wmask) | (wshift & wmask);

  // Contents survive reset; an aborted write never reaches finish.
  always_ff @(posedge clk) begin
    if (finish && wr_q && !err_q) data_memory[idx] <= wnew;
  end

  assign bus.read_data = rdata_q;
  assign bus.mem_ready = (state_q == DONE);
  assign bus.mem_error = (state_q == DONE) && err_q;
  assign bus.mem_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mips_data_mem.sv
// Scoreboard bench for mips_data_mem at LATENCY 0, 2 and 15.
// Driver queues expected responses; per-bus monitors pop and compare.
module tb_mips_data_mem;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_data_mem_if b0 ();
  mips_data_mem_if b2 ();
  mips_data_mem_if b15 ();

  mips_data_mem #(.DEPTH(256), .LATENCY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  mips_data_mem #(.DEPTH(256), .LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));
  mips_data_mem #(.DEPTH(256), .LATENCY(15)) u15 (
    .clk(clk), .rst_n(rst_n), .bus(b15));

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          acc;
  } exp_t;

  // index 0: LATENCY 0, 1: LATENCY 2, 2: LATENCY 15
  exp_t q [3][$];

  task automatic cmp(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic rdy(input int b);
    case (b)
      0:       return b0.mem_ready;
      1:       return b2.mem_ready;
      default: return b15.mem_ready;
    endcase
  endfunction

  function automatic logic bsy(input int b);
    case (b)
      0:       return b0.mem_busy;
      1:       return b2.mem_busy;
      default: return b15.mem_busy;
    endcase
  endfunction

  task automatic drive(input int b, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic un);
    case (b)
      0: begin
        b0.signal_mem_read = rd;  b0.signal_mem_write = wr;
        b0.address = a;  b0.write_data = wd;
        b0.access_size = sz;  b0.signal_unsigned = un;
      end
      1: begin
        b2.signal_mem_read = rd;  b2.signal_mem_write = wr;
        b2.address = a;  b2.write_data = wd;
        b2.access_size = sz;  b2.signal_unsigned = un;
      end
      default: begin
        b15.signal_mem_read = rd;  b15.signal_mem_write = wr;
        b15.address = a;  b15.write_data = wd;
        b15.access_size = sz;  b15.signal_unsigned = un;
      end
    endcase
  endtask

  // Latency = edges from the accept edge to the edge at which a
  // synchronous requester first samples mem_ready high.
  task automatic mon(input int b, input logic [31:0] rd,
                     input logic er);
    exp_t e;
    int   lat;
    int   lexp;
    lexp = (b == 0) ? 2 : (b == 1) ? 4 : 17;
    if (q[b].size() == 0) begin
      cmp("unexpected_ready", 32'd1, 32'd0);
    end else begin
      e = q[b].pop_front();
      lat = cyc + 1 - e.acc;
      cmp("read_data", rd, e.d);
      cmp("mem_error", {31'b0, er}, {31'b0, e.e});
      cmp("latency", lat, lexp);
    end
  endtask

  always @(negedge clk) if (b0.mem_ready)
    mon(0, b0.read_data, b0.mem_error);
  always @(negedge clk) if (b2.mem_ready)
    mon(1, b2.read_data, b2.mem_error);
  always @(negedge clk) if (b15.mem_ready)
    mon(2, b15.read_data, b15.mem_error);

  // Called at a negedge; issues one access and waits for its DONE.
  task automatic req(input int b, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic un,
                     input logic [31:0] ed, input logic ee);
    int   n;
    logic ok;
    n = 0;
    while (bsy(b) && n < 40) begin
      @(negedge clk);
      n++;
    end
    drive(b, rd, wr, a, wd, sz, un);
    q[b].push_back('{d: ed, e: ee, acc: cyc + 1});
    @(negedge clk);
    drive(b, 1'b0, 1'b0, a, wd, sz, un);
    ok = 1'b1;
    n = 0;
    while (!rdy(b) && n < 40) begin
      if (!bsy(b)) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    cmp("ready_timeout", {31'b0, n >= 40}, 32'd0);
    cmp("busy_held", {31'b0, ok & bsy(b)}, 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string n, input logic [31:0] rd);
    cmp({n, "_read_data"}, b2.read_data, rd);
    cmp({n, "_ready"}, {31'b0, b2.mem_ready}, 32'd0);
    cmp({n, "_error"}, {31'b0, b2.mem_error}, 32'd0);
    cmp({n, "_busy"}, {31'b0, b2.mem_busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) drive(i, 0, 0, 0, 0, 2'b00, 0);
    repeat (3) @(negedge clk);
    chk_idle("reset", 32'h0);
    rst_n = 1'b1;

    // first request lands on the first edge after reset release
    req(1, 0, 1, 32'h8, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0);
    req(1, 1, 0, 32'h8, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0);

    req(1, 0, 1, 32'h0, 32'h80FF7F01, 2'b10, 0, 32'hDEADBEEF, 0);
    req(1, 1, 0, 32'h1, 32'h0, 2'b00, 0, 32'hFFFFFFFF, 0);
    req(1, 1, 0, 32'h1, 32'h0, 2'b00, 1, 32'h000000FF, 0);
    req(1, 1, 0, 32'h2, 32'h0, 2'b01, 0, 32'h00007F01, 0);
    req(1, 1, 0, 32'h0, 32'h0, 2'b01, 0, 32'hFFFF80FF, 0);
    req(1, 1, 0, 32'h3, 32'h0, 2'b00, 0, 32'h00000001, 0);

    req(1, 0, 1, 32'h10, 32'h11223344, 2'b10, 0, 32'h00000001, 0);
    req(1, 0, 1, 32'h12, 32'h000000AA, 2'b00, 0, 32'h00000001, 0);
    req(1, 1, 0, 32'h10, 32'h0, 2'b10, 0, 32'h1122AA44, 0);
    req(1, 0, 1, 32'h10, 32'h0000BEEF, 2'b01, 0, 32'h1122AA44, 0);
    req(1, 1, 0, 32'h10, 32'h0, 2'b01, 1, 32'h0000BEEF, 0);

    req(1, 1, 1, 32'h10, 32'h0, 2'b10, 0, 32'h0000BEEF, 1);
    req(1, 1, 0, 32'h10, 32'h0, 2'b10, 0, 32'hBEEFAA44, 0);
    req(1, 1, 0, 32'h400, 32'h0, 2'b10, 0, 32'hBEEFAA44, 1);
    req(1, 0, 1, 32'h400, 32'hFFFFFFFF, 2'b10, 0, 32'hBEEFAA44, 1);
    req(1, 1, 0, 32'h0, 32'h0, 2'b10, 0, 32'h80FF7F01, 0);
    req(1, 1, 0, 32'h0, 32'h0, 2'b11, 0, 32'h80FF7F01, 1);
`ifdef MIPS_DATA_MEM_ALIGN_CHECK_EN
    req(1, 1, 0, 32'h2, 32'h0, 2'b10, 0, 32'h80FF7F01, 1);
    req(1, 1, 0, 32'h11, 32'h0, 2'b01, 1, 32'h80FF7F01, 1);
`else
    req(1, 1, 0, 32'h13, 32'h0, 2'b10, 0, 32'hBEEFAA44, 0);
    req(1, 1, 0, 32'h11, 32'h0, 2'b01, 1, 32'h0000BEEF, 0);
`endif

    req(1, 0, 1, 32'h14, 32'hCAFEF00D, 2'b10, 0, 32'h0000BEEF, 0);
    req(1, 1, 0, 32'h14, 32'h0, 2'b10, 0, 32'hCAFEF00D, 0);
`ifdef MIPS_DATA_MEM_ALIGN_CHECK_EN
`else
`endif

    // write in flight, reset pulled mid-BUSY
    drive(1, 0, 1, 32'h14, 32'h12345678, 2'b10, 0);
    @(negedge clk);
    drive(1, 0, 0, 32'h14, 32'h12345678, 2'b10, 0);
    cmp("abort_busy_before", {31'b0, b2.mem_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("abort", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req(1, 1, 0, 32'h14, 32'h0, 2'b10, 0, 32'hCAFEF00D, 0);

    req(0, 0, 1, 32'h4, 32'h01234567, 2'b10, 0, 32'h0, 0);
    req(0, 1, 0, 32'h4, 32'h0, 2'b10, 0, 32'h01234567, 0);
    req(2, 0, 1, 32'h4, 32'h76543210, 2'b10, 0, 32'h0, 0);
    req(2, 1, 0, 32'h4, 32'h0, 2'b10, 0, 32'h76543210, 0);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) cmp("drain", q[i].size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mips_data_mem.md
MIPS_DATA_MEM -- requirements
Module: mips_data_mem

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words; power of two, 16..65536.
REQ-002 Parameter LATENCY, default 2: wait cycles per access, 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 signal_mem_read  input  1  read request; sampled only in IDLE.
REQ-006 signal_mem_write  input  1  write request; sampled only in IDLE.
REQ-007 address  input  32  byte address; big-endian, byte 0 = bits [31:24].
REQ-008 write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 access_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 signal_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
REQ-011 read_data  output  32  load result, right-aligned and extended.
REQ-012 mem_ready  output  1  one-cycle completion pulse.
REQ-013 mem_error  output  1  one-cycle error pulse, coincident with mem_ready.
REQ-014 mem_busy  output  1  high in BUSY and DONE.

Function
REQ-015 Storage is a register array data_memory[0:DEPTH-1] of 32 bits; word index = address[log2(DEPTH)+1:2].
REQ-016 FSM states are IDLE, BUSY and DONE.
REQ-017 IDLE -> BUSY when either request is high at a clock edge; address, write_data, access_size, signal_unsigned and the operation are captured at that edge.
REQ-018 BUSY counts down a counter loaded with LATENCY; BUSY -> DONE when the counter is 0, so LATENCY=0 spends exactly one cycle in BUSY.
REQ-019 DONE -> IDLE unconditionally; mem_ready=1 during DONE only, so mem_ready rises LATENCY+2 edges after the accept edge.
REQ-020 Requests are ignored outside IDLE, and back-to-back accesses need the requester to hold or re-assert the request in IDLE.
REQ-021 A write commits to data_memory on the BUSY->DONE edge, modifying only the addressed byte lanes: byte lane = address[1:0], half lane = address[1].
REQ-022 A read loads read_data on the BUSY->DONE edge, and read_data holds until the next successful read completes.
REQ-023 Error conditions: both requests high; access_size=11; address >= 4*DEPTH; misalignment per REQ-032.
REQ-024 On error the access still runs the full BUSY/DONE sequence, memory is unmodified, read_data is unchanged, and mem_error=1 with mem_ready in DONE.
REQ-025 Sign/zero extension applies to byte and half loads only; word loads pass through unchanged.

Reset
REQ-026 rst_n low forces IDLE immediately, clears the counter, and sets read_data=0, mem_ready=0, mem_error=0 and mem_busy=0.
REQ-027 Reset asserted during BUSY aborts the access, and a write in flight is not committed.
REQ-028 data_memory contents are not reset; initialisation is by $readmemb from the bench.
REQ-029 The first request is accepted on the first rising edge with rst_n high.

Configuration
REQ-030 Macro MIPS_DATA_MEM_ALIGN_CHECK_EN controls alignment checking.
REQ-031 Without the macro, misaligned half/word accesses ignore the low address bits: half uses address[1] only, word ignores address[1:0].
REQ-032 With the macro, a half access with address[0]=1 or a word access with address[1:0]!=00 is an error per REQ-024.

Verification
REQ-033 LATENCY=2: word write 0xDEADBEEF at address 0x8, then word read 0x8 -> mem_ready 4 edges after each accept; read_data=0xDEADBEEF.
REQ-034 Memory word 0 = 0x80FF7F01: byte read at address 1 signed -> 0xFFFFFFFF; unsigned -> 0x000000FF; half read at address 2 signed -> 0x00007F01.
REQ-035 Word 4 = 0x11223344: byte write 0xAA at address 0x12 -> word 4 = 0x1122AA44.
REQ-036 Read and write high together, or address 4*DEPTH -> mem_error=1 with mem_ready, memory and read_data unchanged; with MIPS_DATA_MEM_ALIGN_CHECK_EN, word read at 0x2 -> mem_error=1.
REQ-037 Write issued, then rst_n low for one cycle mid-BUSY -> outputs cleared immediately, target word unchanged, FSM in IDLE.
REQ-038 LATENCY=0 and LATENCY=15 -> mem_ready rises 2 and 17 edges after accept; mem_busy high throughout.
